// File: rtl/fadd_sub_ctrl.sv
// -----------------------------------------------------------------------------
// fadd_sub_ctrl
//
// Sequencer for the multi-cycle FADD.S / FSUB.S datapath. One operation is
// in flight at a time. The controller walks the datapath through
// extract/align, mantissa add, normalize and round, firing one register load
// enable per stage. It then holds the result under a valid/ready handshake.
//
// A NaN/infinity operand reported by the align stage can bypass the add and
// normalize stages (SKIP_SPECIAL = 1). The instruction rounding mode is
// resolved against fcsr.frm when the operation is accepted. Reserved rounding
// modes are rejected with a one-cycle illegal_rm pulse.
//
// Parameters
//   SKIP_SPECIAL  1: a special operand seen in ALIGN jumps straight to ROUND
//   CNT_W         width of the completed-operation counter
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   operation request handshake from FP issue
//   op_sub                1 = FSUB.S, 0 = FADD.S
//   rm_inst, frm          instruction rm field and fcsr.frm
//   special_i             NaN/inf flag from the align stage (used in ALIGN)
//   kill                  pipeline flush, returns the controller to IDLE
//   en_align .. en_round  per-stage register load enables (one-hot or zero)
//   rm_eff, sub_eff       rounding mode and operation latched at accept
//   out_valid / out_ready result handshake to the core
//   illegal_rm            one-cycle pulse: request rejected, bad rounding mode
//   busy                  controller is not idle
//   op_count              completed-operation counter (wraps)
// -----------------------------------------------------------------------------
module fadd_sub_ctrl #(
    parameter int unsigned SKIP_SPECIAL = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [2:0]       rm_inst,
    input  logic [2:0]       frm,
    input  logic             special_i,
    input  logic             kill,
    output logic             en_align,
    output logic             en_add,
    output logic             en_norm,
    output logic             en_round,
    output logic [2:0]       rm_eff,
    output logic             sub_eff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             illegal_rm,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic rm_ok;
    logic req;
    logic accept;
    logic handshake;

    // Rounding modes 000..100 are defined. 101 and 110 are reserved. 111
    // (DYN) defers to frm, which itself must hold a defined mode.
    function automatic logic rm_legal(input logic [2:0] rm, input logic [2:0] dyn);
        if (rm == 3'b111) begin
            return (dyn <= 3'd4);
        end
        return (rm <= 3'd4);
    endfunction

    function automatic logic [2:0] rm_resolve(input logic [2:0] rm, input logic [2:0] dyn);
        return (rm == 3'b111) ? dyn : rm;
    endfunction

    // Request qualification. A kill blocks acceptance in the same cycle.
    // An illegal request is still "seen" so that it can be flagged.
    always_comb begin
        rm_ok      = rm_legal(rm_inst, frm);
        in_ready   = !kill && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
        req        = in_valid && in_ready;
        accept     = req && rm_ok;
        illegal_rm = req && !rm_ok;
        handshake  = (state == S_DONE) && out_ready && !kill;
        out_valid  = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    // Next-state and stage enables
    always_comb begin
        state_nxt = state;
        en_align  = 1'b0;
        en_add    = 1'b0;
        en_norm   = 1'b0;
        en_round  = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: begin
                en_align = 1'b1;
                if (special_i && (SKIP_SPECIAL != 0)) begin
                    state_nxt = S_ROUND;
                end else begin
                    state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                en_add    = 1'b1;
                state_nxt = S_NORM;
            end
            S_NORM: begin
                en_norm   = 1'b1;
                state_nxt = S_ROUND;
            end
            S_ROUND: begin
                en_round  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                // The result is held until consumed. A request arriving
                // with out_ready starts the next operation back-to-back.
                if (out_ready) begin
                    state_nxt = accept ? S_ALIGN : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The flush overrides everything: no stage may load this cycle.
        if (kill) begin
            state_nxt = S_IDLE;
            en_align  = 1'b0;
            en_add    = 1'b0;
            en_norm   = 1'b0;
            en_round  = 1'b0;
        end
    end

    // State, latched operation attributes and completion counter.
    // rm_eff/sub_eff change only on accept, so they stay stable for the
    // whole operation and survive a kill.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rm_eff   <= 3'b000;
            sub_eff  <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rm_eff  <= rm_resolve(rm_inst, frm);
                sub_eff <= op_sub;
            end
            if (handshake) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/fadd_sub_ctrl.md
Name: fadd_sub_ctrl

Overview:
- Multi-cycle sequencer for the FP add/sub datapath: extract/align, mantissa add, normalize, round.
- Accepts one FADD.S/FSUB.S at a time from the core FP issue logic and resolves the effective rounding mode.
- Fires one register enable per datapath stage, short-circuits NaN/infinity operands, and holds the result under a valid/ready handshake.
- Counts completed operations for the performance CSR.

Parameters:
- SKIP_SPECIAL, 1, when 1 a special operand detected in ALIGN jumps straight to ROUND; when 0 the full stage sequence always runs.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  core presents an add/sub operation
- in_ready  output  1  controller can accept an operation this cycle
- op_sub  input  1  1 = FSUB.S, 0 = FADD.S
- rm_inst  input  3  instruction rm field
- frm  input  3  fcsr.frm value
- special_i  input  1  from the align stage: NaN or inf1/inf2 detected; sampled only in ALIGN
- kill  input  1  pipeline flush from the core
- en_align  output  1  load enable for the extract/align register
- en_add  output  1  load enable for the add register
- en_norm  output  1  load enable for the normalize register
- en_round  output  1  load enable for the round/result register
- rm_eff  output  3  effective rounding mode to the round stage
- sub_eff  output  1  latched op_sub
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  core consumes the result
- illegal_rm  output  1  one-cycle pulse: rounding mode invalid, operation rejected
- busy  output  1  high in any state other than IDLE
- op_count  output  CNT_W  completed-operation count

Behaviour:
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- Reset values: state = IDLE, all enables = 0, out_valid = 0, illegal_rm = 0, rm_eff = 0, sub_eff = 0, op_count = 0, busy = 0.
- in_ready = (state == IDLE) || (state == DONE && out_ready); forced 0 when kill = 1.
- Accept = in_valid && in_ready && !kill && rm legal.
  - On accept, latch rm_eff and sub_eff.
  - rm_eff = frm when rm_inst == 3'b111, otherwise rm_inst.
- Illegal rm:
  - Condition: rm_inst is 101 or 110, or rm_inst == 111 with frm in {101, 110, 111}.
  - Action: pulse illegal_rm for 1 cycle, do not accept, stay in or return to IDLE. The core discards the instruction.
- Transitions (one cycle per state):
  - IDLE -> ALIGN on accept.
  - ALIGN -> ADD, or ALIGN -> ROUND when special_i && SKIP_SPECIAL.
  - ADD -> NORM -> ROUND -> DONE.
- Stage enables: each en_* is asserted exactly in its state (en_align in ALIGN, en_add in ADD, en_norm in NORM, en_round in ROUND); at most one en_* is high per cycle.
- Latency from the accept edge to out_valid = 1:
  - normal path: 5 cycles;
  - special path with SKIP_SPECIAL = 1: 3 cycles.
- DONE:
  - out_valid = 1, held stable with the result until out_ready.
  - out_ready = 1 with a new accept (back-to-back): go to ALIGN.
  - out_ready = 1 without a new accept: go to IDLE.
  - out_ready = 0: stay in DONE, no enables.
- op_count increments by 1 on every out_valid && out_ready handshake, wraps modulo 2^CNT_W.
- kill (any state, priority over everything except reset):
  - next state = IDLE, all enables 0 that cycle, out_valid drops next cycle;
  - no op_count increment, even if out_ready is also high in DONE;
  - rm_eff/sub_eff retain their values.
- reset mid-operation: same as reset values above; op_count is cleared.
- rm_eff and sub_eff are stable from ALIGN through DONE; they change only on accept.

Test Plan:
- FADD, rm_inst = 000, no special, out_ready = 1 -> en_align/add/norm/round each high for 1 cycle on cycles 1-4 after accept; out_valid at cycle 5; op_count 0 -> 1.
- rm_inst = 111, frm = 011 -> rm_eff = 011. rm_inst = 111, frm = 101 -> illegal_rm for 1 cycle, in_ready stays 1, no en_align.
- special_i = 1 in ALIGN, SKIP_SPECIAL = 1 -> en_round on cycle 2, out_valid on cycle 3, en_add/en_norm never asserted. With SKIP_SPECIAL = 0 -> 5-cycle path.
- out_ready held 0 for 4 cycles in DONE -> out_valid stays high, no enables, in_ready = 0. Then out_ready = 1 with in_valid = 1 -> next state ALIGN, op_count +1.
- kill asserted in NORM -> IDLE next cycle, no en_round, no out_valid, op_count unchanged. kill with in_valid in IDLE -> not accepted.
- op_count preset near 2^CNT_W - 1 (CNT_W = 4 build), 2 completions -> count 15 -> 0 -> 1. reset asserted in ADD -> all outputs at reset values next cycle.
